se_sram_arbiter_2port: RTL and testbench
========================================

# se_sram_arbiter_2port

Two-client round-robin front end for one `se_sram_srw` instance. Each client issues single-word read or write requests with a valid/ack handshake. The block multiplexes the granted request onto the SRAM ports and routes the SRAM's one-cycle registered read data back to the originating client as a registered response pulse. It sits directly upstream of the SRAM and is the only driver of its control, address and data inputs.

## Interface
Parameters:
- `address_width`, 16: SRAM address bits; must match the attached SRAM.
- `data_width`, 32: SRAM word width.

Ports:
- `clk`  in  1: single clock; the SRAM is clocked from the same net.
- `clk__enable`  in  1: all state advances only when high; the integrator ties it to the SRAM `sram_clock__enable`.
- `reset_n`  in  1: asynchronous, active-low reset.
- `a_req_valid`  in  1: client A holds a request.
- `a_req_read_not_write`  in  1: client A read (1) or write (0).
- `a_req_address`  in  address_width: client A address.
- `a_req_write_data`  in  data_width: client A write data.
- `a_req_ack`  out  1: client A request accepted this cycle.
- `a_rsp_valid`  out  1: one-cycle pulse; `a_rsp_data` holds new read data.
- `a_rsp_data`  out  data_width: last read data returned to A.
- `b_*`: identical set for client B.
- `sram_select`, `sram_read_not_write`, `sram_write_enable`  out  1: SRAM controls.
- `sram_address`  out  address_width: SRAM address.
- `sram_write_data`  out  data_width: SRAM write data.
- `sram_data_out`  in  data_width: SRAM registered read data.

## Operation
- Handshake: a client raises `req_valid` with stable fields and holds them until it sees `req_ack` high on an enabled edge. `req_ack` is combinational from the valid inputs and the `last_grant` register, and may be high in the same cycle as `req_valid` rises.
- Arbitration: one grant per enabled cycle.
  - Only one client valid: that client is granted.
  - Both valid: the client not named by `last_grant` is granted.
  - `last_grant` (1 bit, 0 = A, 1 = B) updates to the granted client on each enabled edge that grants.
  - Neither valid: no grant, and `last_grant` holds its value.
- SRAM drive:
  - When granted: `sram_select`=1, `sram_read_not_write` = the client's bit, `sram_write_enable` = the inverse of that bit; address and write data come from the granted client.
  - When idle: all three controls are 0, and address and write data are 0.
- Read return:
  - On a granted read, the `pending_valid`/`pending_client` registers are set on that edge.
  - On the next enabled edge, `sram_data_out` is captured into that client's `rsp_data`, that client's `rsp_valid` is set, and `pending_valid` reloads from the current grant.
  - `rsp_valid` clears on the following enabled edge unless a new read return for the same client lands on that edge.
  - `rsp_data` holds its value between responses.
- Writes produce no response.
- Back-to-back reads to alternating or the same client are sustained at one per cycle.
- `clk__enable` low: every register holds, and `req_ack` is forced 0. SRAM outputs may still toggle, which is harmless because the SRAM is also disabled.

## Timing
- Reset values: `last_grant`=1 (A wins the first conflict), `pending_valid`=0, `a_rsp_valid`=`b_rsp_valid`=0, `a_rsp_data`=`b_rsp_data`=0. With both `req_valid` inputs low, `req_ack` and the SRAM controls are 0.
- Read latency: request acked in cycle N; SRAM data is valid in N+1; `rsp_valid` pulse and `rsp_data` appear in N+2.
- Worst-case wait for a requester held continuously: 1 cycle. A request is never starved.
- A write then a read to the same address in consecutive cycles returns the new data; SRAM ordering alone guarantees this.
- Reset asserted mid-operation: pending read discarded, no response is issued after reset, and an unacked request must be re-presented.
- A `clk__enable` low gap between request and return stretches latency by the gap length. Data is not lost, because the SRAM's `data_out` also holds.

## Structure
- Shared package `se_sram_arbiter_pkg`:
  - client-id constants `SE_CLIENT_A`=0 and `SE_CLIENT_B`=1;
  - a typedef for the pending record `{valid, client}`.
- One natural sub-module: `se_rr_arbiter_2`, holding combinational grant logic plus the `last_grant` register (inputs `clk`, `clk__enable`, `reset_n`, two requests; outputs two one-hot grants).
- The datapath mux and response registers stay in the top module.

## Test plan
- Single read, A only: preload addr 0x0010=0xDEADBEEF; A reads at cycle 5 → `a_req_ack`=1 at 5; `a_rsp_valid`=1 at 7 only, with `a_rsp_data`=0xDEADBEEF; B outputs quiet.
- Conflict fairness: A and B both hold reads continuously from reset for 8 cycles → grants ordered A,B,A,B…; each client gets exactly 4 acks; responses alternate with matching data.
- Write-then-read: A writes 0x12345678 to 0x0020 at cycle N, B reads 0x0020 at N+1 → `b_rsp_data`=0x12345678 at N+3; no `a_rsp_valid`.
- Enable gaps: A reads with `clk__enable` low for 3 cycles after the ack edge → response arrives 3 cycles late with correct data; no duplicate pulse.
- Reset mid-read: `reset_n` asserted asynchronously 1 cycle after an A read is acked → all `rsp_valid` stay 0 after release; `last_grant` reads 1 (next conflict grants A).
- Same-client streaming: B issues 4 consecutive reads of addresses 0..3 → four consecutive `b_rsp_valid` cycles with data in address order.

Source files
------------

// File: rtl/se_sram_arbiter_pkg.sv
// Shared types for the two-client SRAM arbiter: client ids and the
// in-flight read record.
package se_sram_arbiter_pkg;

  typedef enum logic {
    SE_CLIENT_A = 1'b0,
    SE_CLIENT_B = 1'b1
  } se_client_e;

  typedef struct packed {
    logic       valid;
    se_client_e client;
  } pending_t;

endpackage

// File: rtl/se_sram_arbiter_2port_if.sv
// Client handshakes plus SRAM-side bus for se_sram_arbiter_2port.
// slave = arbiter side, master = clients/SRAM environment side.
interface se_sram_arbiter_2port_if #(
  parameter int address_width = 16,
  parameter int data_width    = 32
);
  logic                     a_req_valid;
  logic                     a_req_read_not_write;
  logic [address_width-1:0] a_req_address;
  logic [data_width-1:0]    a_req_write_data;
  logic                     a_req_ack;
  logic                     a_rsp_valid;
  logic [data_width-1:0]    a_rsp_data;

  logic                     b_req_valid;
  logic                     b_req_read_not_write;
  logic [address_width-1:0] b_req_address;
  logic [data_width-1:0]    b_req_write_data;
  logic                     b_req_ack;
  logic                     b_rsp_valid;
  logic [data_width-1:0]    b_rsp_data;

  logic                     sram_select;
  logic                     sram_read_not_write;
  logic                     sram_write_enable;
  logic [address_width-1:0] sram_address;
  logic [data_width-1:0]    sram_write_data;
  logic [data_width-1:0]    sram_data_out;

  modport slave (
    input  a_req_valid, a_req_read_not_write, a_req_address, a_req_write_data,
    output a_req_ack, a_rsp_valid, a_rsp_data,
    input  b_req_valid, b_req_read_not_write, b_req_address, b_req_write_data,
    output b_req_ack, b_rsp_valid, b_rsp_data,
    output sram_select, sram_read_not_write, sram_write_enable,
    output sram_address, sram_write_data,
    input  sram_data_out
  );

  modport master (
    output a_req_valid, a_req_read_not_write, a_req_address, a_req_write_data,
    input  a_req_ack, a_rsp_valid, a_rsp_data,
    output b_req_valid, b_req_read_not_write, b_req_address, b_req_write_data,
    input  b_req_ack, b_rsp_valid, b_rsp_data,
    input  sram_select, sram_read_not_write, sram_write_enable,
    input  sram_address, sram_write_data,
    output sram_data_out
  );
endinterface

// File: rtl/se_rr_arbiter_2.sv
// Two-way round-robin arbiter: combinational one-hot grant, last_grant
// register remembers who won so the other client wins the next conflict.
module se_rr_arbiter_2
  import se_sram_arbiter_pkg::*;
(
  input  logic clk,
  input  logic clk__enable,
  input  logic reset_n,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  se_client_e last_grant_q, last_grant_d;

  always_comb begin
    gnt_a        = 1'b0;
    gnt_b        = 1'b0;
    last_grant_d = last_grant_q;
    // Grants are suppressed while disabled so no ack is seen on a held edge.
    if (clk__enable) begin
      gnt_a = req_a & (~req_b | (last_grant_q == SE_CLIENT_B));
      gnt_b = req_b & (~req_a | (last_grant_q == SE_CLIENT_A));
    end
    if (gnt_a)      last_grant_d = SE_CLIENT_A;
    else if (gnt_b) last_grant_d = SE_CLIENT_B;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         last_grant_q <= SE_CLIENT_B;
    else if (clk__enable) last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/se_sram_arbiter_2port.sv
// Two-client round-robin front end for a single-port SRAM with one-cycle
// registered read data; routes read returns back as a registered pulse.
module se_sram_arbiter_2port
  import se_sram_arbiter_pkg::*;
#(
  parameter int address_width = 16,
  parameter int data_width    = 32
) (
  input  logic clk,
  input  logic clk__enable,
  input  logic reset_n,
  se_sram_arbiter_2port_if.slave bus
);

  logic gnt_a, gnt_b, gnt_any, gnt_rnw;

  pending_t              pending_q, pending_d;
  logic                  a_rsp_valid_q, a_rsp_valid_d;
  logic                  b_rsp_valid_q, b_rsp_valid_d;
  logic [data_width-1:0] a_rsp_data_q, a_rsp_data_d;
  logic [data_width-1:0] b_rsp_data_q, b_rsp_data_d;

  se_rr_arbiter_2 u_arb (
    .clk        (clk),
    .clk__enable(clk__enable),
    .reset_n    (reset_n),
    .req_a      (bus.a_req_valid),
    .req_b      (bus.b_req_valid),
    .gnt_a      (gnt_a),
    .gnt_b      (gnt_b)
  );

  always_comb begin
    gnt_any = gnt_a | gnt_b;
    gnt_rnw = gnt_b ? bus.b_req_read_not_write : bus.a_req_read_not_write;

    bus.a_req_ack           = gnt_a;
    bus.b_req_ack           = gnt_b;
    bus.sram_select         = gnt_any;
    bus.sram_read_not_write = gnt_any & gnt_rnw;
    bus.sram_write_enable   = gnt_any & ~gnt_rnw;
    bus.sram_address        = '0;
    bus.sram_write_data     = '0;
    if (gnt_a) begin
      bus.sram_address    = bus.a_req_address;
      bus.sram_write_data = bus.a_req_write_data;
    end else if (gnt_b) begin
      bus.sram_address    = bus.b_req_address;
      bus.sram_write_data = bus.b_req_write_data;
    end
  end

  // The read granted now has its SRAM data on the next edge; pending tracks
  // whose it is so that edge can steer it into the right response register.
  always_comb begin
    pending_d.valid  = gnt_any & gnt_rnw;
    pending_d.client = gnt_b ? SE_CLIENT_B : SE_CLIENT_A;

    a_rsp_valid_d = pending_q.valid & (pending_q.client == SE_CLIENT_A);
    b_rsp_valid_d = pending_q.valid & (pending_q.client == SE_CLIENT_B);
    a_rsp_data_d  = a_rsp_valid_d ? bus.sram_data_out : a_rsp_data_q;
    b_rsp_data_d  = b_rsp_valid_d ? bus.sram_data_out : b_rsp_data_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q     <= '{valid: 1'b0, client: SE_CLIENT_A};
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
      a_rsp_data_q  <= '0;
      b_rsp_data_q  <= '0;
    end else if (clk__enable) begin
      pending_q     <= pending_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      b_rsp_valid_q <= b_rsp_valid_d;
      a_rsp_data_q  <= a_rsp_data_d;
      b_rsp_data_q  <= b_rsp_data_d;
    end
  end

  assign bus.a_rsp_valid = a_rsp_valid_q;
  assign bus.b_rsp_valid = b_rsp_valid_q;
  assign bus.a_rsp_data  = a_rsp_data_q;
  assign bus.b_rsp_data  = b_rsp_data_q;

endmodule

// File: tb/tb_se_sram_arbiter_2port.sv
// Bench for se_sram_arbiter_2port: behavioural SRAM, transaction-level
// reference model, grant table, directed corner sequences, random traffic.
module tb_se_sram_arbiter_2port;
  localparam int AW = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic clk__enable;
  logic reset_n;
  always #5 clk = ~clk;

  se_sram_arbiter_2port_if #(.address_width(AW), .data_width(DW)) bus ();

  se_sram_arbiter_2port #(.address_width(AW), .data_width(DW)) dut (
    .clk        (clk),
    .clk__enable(clk__enable),
    .reset_n    (reset_n),
    .bus        (bus)
  );

  // Behavioural SRAM: registered read data that holds when not read.
  logic [DW-1:0] sram_mem [0:65535];
  logic [DW-1:0] sram_q = '0;
  always @(posedge clk) begin
    if (clk__enable && bus.sram_select) begin
      if (bus.sram_write_enable)        sram_mem[bus.sram_address] <= bus.sram_write_data;
      else if (bus.sram_read_not_write) sram_q <= sram_mem[bus.sram_address];
    end
  end
  assign bus.sram_data_out = sram_q;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: memory contents, round-robin owner, reads in flight.
  typedef struct {
    int            client;
    logic [DW-1:0] data;
    int            left;
  } ret_t;
  logic [DW-1:0] m_mem [int];
  int            m_last;
  ret_t          rq[$];
  logic [1:0]    m_rsp_v;
  logic [DW-1:0] m_rsp_d [2];

  function automatic logic [DW-1:0] mem_rd(input int a);
    return m_mem.exists(a) ? m_mem[a] : '0;
  endfunction

  task automatic model_reset();
    m_last = 1; rq = {}; m_rsp_v = '0; m_rsp_d[0] = '0; m_rsp_d[1] = '0;
  endtask

  task automatic model_edge(input int win, input logic rd, input logic [AW-1:0] ad,
                            input logic [DW-1:0] wd);
    ret_t nq[$];
    m_rsp_v = '0;
    foreach (rq[i]) begin
      ret_t r = rq[i];
      r.left--;
      if (r.left == 0) begin
        m_rsp_v[r.client] = 1'b1;
        m_rsp_d[r.client] = r.data;
      end else nq.push_back(r);
    end
    rq = nq;
    if (win >= 0) begin
      m_last = win;
      if (rd) rq.push_back('{client: win, data: mem_rd(int'(ad)), left: 1});
      else    m_mem[int'(ad)] = wd;
    end
  endtask

  logic s_ack_a, s_ack_b, s_sel, s_av, s_bv;
  logic [DW-1:0] s_ad, s_bd;

  // One clock: compare DUT to model at negedge, advance model at posedge.
  task automatic cycle();
    int win;
    logic rd;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    @(negedge clk);
    win = -1;
    if (clk__enable) begin
      if (bus.a_req_valid && bus.b_req_valid) win = 1 - m_last;
      else if (bus.a_req_valid)               win = 0;
      else if (bus.b_req_valid)               win = 1;
    end
    rd = (win == 1) ? bus.b_req_read_not_write : bus.a_req_read_not_write;
    ad = (win == 1) ? bus.b_req_address : bus.a_req_address;
    wd = (win == 1) ? bus.b_req_write_data : bus.a_req_write_data;
    s_ack_a = bus.a_req_ack; s_ack_b = bus.b_req_ack; s_sel = bus.sram_select;
    s_av = bus.a_rsp_valid;  s_bv = bus.b_rsp_valid;
    s_ad = bus.a_rsp_data;   s_bd = bus.b_rsp_data;
    chk("ack_a", s_ack_a, win == 0);
    chk("ack_b", s_ack_b, win == 1);
    if (clk__enable) begin
      chk("sram_select", s_sel, win >= 0);
      chk("sram_rnw", bus.sram_read_not_write, win >= 0 && rd);
      chk("sram_we", bus.sram_write_enable, win >= 0 && !rd);
      chk("sram_addr", bus.sram_address, (win >= 0) ? ad : '0);
      chk("sram_wdata", bus.sram_write_data, (win >= 0) ? wd : '0);
    end
    chk("a_rsp_valid", s_av, m_rsp_v[0]);
    chk("b_rsp_valid", s_bv, m_rsp_v[1]);
    chk("a_rsp_data", s_ad, m_rsp_d[0]);
    chk("b_rsp_data", s_bd, m_rsp_d[1]);
    @(posedge clk);
    if (reset_n && clk__enable) model_edge(win, rd, ad, wd);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic set_a(input logic v, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.a_req_valid = v; bus.a_req_read_not_write = rd; bus.a_req_address = a; bus.a_req_write_data = d;
  endtask

  task automatic set_b(input logic v, input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.b_req_valid = v; bus.b_req_read_not_write = rd; bus.b_req_address = a; bus.b_req_write_data = d;
  endtask

  task automatic write_a(input logic [AW-1:0] a, input logic [DW-1:0] d);
    set_a(1, 0, a, d);
    cycle();
    set_a(0, 0, 0, 0);
  endtask

  typedef struct {
    logic en, va, vb, ack_a, ack_b;
  } vec_t;
  vec_t tv[12];

  initial begin
    int na, nb, first, pulses;
    int pidx[$];
    logic [DW-1:0] pdat[$];
    logic pa, pb;

    tv[0]  = '{1, 0, 0, 0, 0}; tv[1]  = '{1, 1, 1, 1, 0}; tv[2]  = '{1, 1, 1, 0, 1};
    tv[3]  = '{0, 1, 1, 0, 0}; tv[4]  = '{1, 1, 1, 1, 0}; tv[5]  = '{1, 0, 1, 0, 1};
    tv[6]  = '{1, 0, 1, 0, 1}; tv[7]  = '{1, 1, 1, 1, 0}; tv[8]  = '{1, 1, 0, 1, 0};
    tv[9]  = '{1, 1, 1, 0, 1}; tv[10] = '{1, 0, 0, 0, 0}; tv[11] = '{1, 1, 1, 1, 0};

    clk__enable = 1'b1;
    reset_n     = 1'b1;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    #1 do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_a_rsp_valid", bus.a_rsp_valid, 1'b0);
    chk("rst_b_rsp_valid", bus.b_rsp_valid, 1'b0);
    chk("rst_a_rsp_data", bus.a_rsp_data, '0);
    chk("rst_b_rsp_data", bus.b_rsp_data, '0);
    chk("rst_select", bus.sram_select, 1'b0);
    chk("rst_ack_a", bus.a_req_ack, 1'b0);
    @(posedge clk); #1;

    // Grant table (writes only), starting from reset owner state
    do_reset();
    foreach (tv[i]) begin
      clk__enable = tv[i].en;
      set_a(tv[i].va, 0, AW'(i), DW'(32'h100 + i));
      set_b(tv[i].vb, 0, AW'(i), DW'(32'h200 + i));
      cycle();
      chk($sformatf("tv%0d_ack_a", i), s_ack_a, tv[i].ack_a);
      chk($sformatf("tv%0d_ack_b", i), s_ack_b, tv[i].ack_b);
      if (tv[i].en) chk($sformatf("tv%0d_sel", i), s_sel, tv[i].ack_a | tv[i].ack_b);
    end
    clk__enable = 1'b1;
    set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);

    // Preload memory through the arbiter
    for (int i = 0; i < 16; i++) write_a(AW'(i), DW'(32'h5000_0000 + i * 32'h11));
    write_a(16'h0010, 32'hDEAD_BEEF);
    write_a(16'h0100, 32'hA0A0_0001);
    write_a(16'h0200, 32'hB0B0_0002);
    write_a(16'h0030, 32'hCAFE_F00D);
    repeat (2) cycle();

    // Single read, A only, at cycle 5 after reset
    do_reset();
    repeat (5) cycle();
    set_a(1, 1, 16'h0010, 0);
    cycle();
    chk("single_ack", s_ack_a, 1'b1);
    set_a(0, 0, 0, 0);
    cycle(); chk("single_n1_valid", s_av, 1'b0);
    cycle(); chk("single_n2_valid", s_av, 1'b1);
    chk("single_n2_data", s_ad, 32'hDEAD_BEEF);
    chk("single_b_quiet", s_bv, 1'b0);
    cycle(); chk("single_n3_valid", s_av, 1'b0);

    // Conflict fairness from reset
    do_reset();
    na = 0; nb = 0;
    set_a(1, 1, 16'h0100, 0);
    set_b(1, 1, 16'h0200, 0);
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk($sformatf("fair%0d_order", i), s_ack_a, (i % 2) == 0);
      na += int'(s_ack_a); nb += int'(s_ack_b);
    end
    chk("fair_count_a", na, 4);
    chk("fair_count_b", nb, 4);
    set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
    repeat (3) cycle();

    // Write then read, same address, consecutive cycles
    set_a(1, 0, 16'h0020, 32'h1234_5678);
    cycle(); chk("wr_ack_a", s_ack_a, 1'b1);
    set_a(0, 0, 0, 0);
    set_b(1, 1, 16'h0020, 0);
    cycle(); chk("rd_ack_b", s_ack_b, 1'b1);
    set_b(0, 0, 0, 0);
    cycle(); chk("wr_rd_n2_valid", s_bv, 1'b0);
    cycle(); chk("wr_rd_n3_valid", s_bv, 1'b1);
    chk("wr_rd_n3_data", s_bd, 32'h1234_5678);
    chk("wr_rd_no_a", s_av, 1'b0);

    // Enable gap of 3 cycles after the ack edge
    set_a(1, 1, 16'h0030, 0);
    cycle(); chk("gap_ack", s_ack_a, 1'b1);
    set_a(0, 0, 0, 0);
    clk__enable = 1'b0;
    repeat (3) cycle();
    clk__enable = 1'b1;
    first = -1; pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (s_av) begin
        pulses++;
        if (first < 0) first = i;
        chk("gap_data", s_ad, 32'hCAFE_F00D);
      end
    end
    chk("gap_latency", first, 1);
    chk("gap_pulses", pulses, 1);

    // Asynchronous reset one cycle after an acked read
    set_a(1, 1, 16'h0010, 0);
    cycle(); chk("rstmid_ack", s_ack_a, 1'b1);
    set_a(0, 0, 0, 0);
    #2 reset_n = 1'b0;
    model_reset();
    repeat (2) cycle();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rstmid_a_quiet", s_av, 1'b0);
      chk("rstmid_b_quiet", s_bv, 1'b0);
    end
    set_a(1, 1, 16'h0001, 0);
    set_b(1, 1, 16'h0002, 0);
    cycle();
    chk("rstmid_conflict_a", s_ack_a, 1'b1);
    chk("rstmid_conflict_b", s_ack_b, 1'b0);
    set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
    repeat (3) cycle();

    // Same-client streaming, B reads 0..3
    pidx = {}; pdat = {};
    for (int i = 0; i < 8; i++) begin
      if (i < 4) set_b(1, 1, AW'(i), 0);
      else       set_b(0, 0, 0, 0);
      cycle();
      if (i < 4) chk($sformatf("stream_ack%0d", i), s_ack_b, 1'b1);
      if (s_bv) begin pidx.push_back(i); pdat.push_back(s_bd); end
    end
    chk("stream_count", pidx.size(), 4);
    foreach (pidx[k]) begin
      chk($sformatf("stream_idx%0d", k), pidx[k], k + 2);
      chk($sformatf("stream_data%0d", k), pdat[k], DW'(32'h5000_0000 + k * 32'h11));
    end

    // Random traffic against the model; requests held until acked
    pa = 0; pb = 0;
    for (int i = 0; i < 400; i++) begin
      clk__enable = ($urandom_range(0, 9) < 8);
      if (!pa && $urandom_range(0, 1)) begin
        set_a(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
        pa = 1;
      end
      if (!pb && $urandom_range(0, 1)) begin
        set_b(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
        pb = 1;
      end
      cycle();
      if (s_ack_a) begin pa = 0; set_a(0, 0, 0, 0); end
      if (s_ack_b) begin pb = 0; set_b(0, 0, 0, 0); end
    end
    clk__enable = 1'b1;
    set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
    repeat (4) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
